// File: rtl/adder_response_checker_if.sv
// Beat channel from the adder sweep into the response checker.
// A beat transfers on a rising clk edge when in_valid && in_ready. The payload
// must be stable while in_valid is high. in_ready never depends on in_valid.
interface adder_response_checker_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, b, c_in, sum, c_out,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, c_in, sum, c_out,
    output in_ready
  );
endinterface

// File: rtl/adder_response_checker.sv
// Hardware response checker for the WIDTH-bit adder sweep: recomputes a+b+c_in
// for every accepted beat, counts beats and mismatches, and keeps the first failure.
module adder_response_checker #(
  parameter int              WIDTH       = 16,
  parameter int              CNT_W       = 34,
  parameter longint unsigned NUM_VECTORS = 64'd1 << (2 * WIDTH + 1),
  parameter int              ERR_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  adder_response_checker_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_count,
  output logic [ERR_W-1:0]      err_count,
  output logic                  first_err_valid,
  output logic [WIDTH-1:0]      first_err_a,
  output logic [WIDTH-1:0]      first_err_b,
  output logic                  first_err_c_in,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // acc_cnt value at the moment the final beat of a run is accepted
  localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(NUM_VECTORS - 64'd1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c_in;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_c_out;

  logic             accept;
  logic [WIDTH:0]   expected;
  logic             mismatch;

  assign bus.in_ready = (state == RUN);
  assign accept       = bus.in_valid && (state == RUN);
  assign dbg_state    = state;

  // MSB of the WIDTH+1 bit result is the expected carry-out
  assign expected = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_c_in};
  assign mismatch = ({s1_c_out, s1_sum} != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      s1_valid        <= 1'b0;
      s1_a            <= '0;
      s1_b            <= '0;
      s1_c_in         <= 1'b0;
      s1_sum          <= '0;
      s1_c_out        <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_c_in  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= bus.a;
        s1_b     <= bus.b;
        s1_c_in  <= bus.c_in;
        s1_sum   <= bus.sum;
        s1_c_out <= bus.c_out;
      end

      if (s1_valid) begin
        vec_count <= vec_count + CNT_W'(1);
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            err_count <= err_count + ERR_W'(1);
          end
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= s1_a;
            first_err_b     <= s1_b;
            first_err_c_in  <= s1_c_in;
          end
        end
      end

      // Run-start clears come after the compare stage so they take priority.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            acc_cnt         <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_c_in  <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST_ACC) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last beat's compare has retired once stage 1 is empty.
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: four instances with different run lengths and
// counter widths share one stimulus bus; each is started and checked separately.
module tb_adder_response_checker;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    int          exp_err_after;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [15:0] va, vb, vs;
  logic        vci, vco;
  logic        start_v [4];

  logic        rdy_v  [4];
  logic        busy_v [4];
  logic        done_v [4];
  logic        pass_v [4];
  logic [33:0] vec_v  [4];
  logic [15:0] err_v  [4];
  logic        fev_v  [4];
  logic [15:0] fea_v  [4];
  logic [15:0] feb_v  [4];
  logic        fec_v  [4];
  logic [1:0]  st_v   [4];

  logic [32:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int EW = (g == 3) ? 2 : 16;
    localparam longint unsigned NV = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 8 : 6;
    adder_response_checker_if #(.WIDTH(16)) bus ();
    logic          busy, done, pass, fev, fec;
    logic [33:0]   vc;
    logic [EW-1:0] ec;
    logic [15:0]   fea, feb;
    logic [1:0]    st;

    assign bus.in_valid = vld;
    assign bus.a        = va;
    assign bus.b        = vb;
    assign bus.c_in     = vci;
    assign bus.sum      = vs;
    assign bus.c_out    = vco;

    adder_response_checker #(
      .WIDTH(16), .CNT_W(34), .NUM_VECTORS(NV), .ERR_W(EW)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start_v[g]),
      .bus             (bus),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .vec_count       (vc),
      .err_count       (ec),
      .first_err_valid (fev),
      .first_err_a     (fea),
      .first_err_b     (feb),
      .first_err_c_in  (fec),
      .dbg_state       (st)
    );

    assign rdy_v[g]  = bus.in_ready;
    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign pass_v[g] = pass;
    assign vec_v[g]  = vc;
    assign err_v[g]  = 16'(ec);
    assign fev_v[g]  = fev;
    assign fea_v[g]  = fea;
    assign feb_v[g]  = feb;
    assign fec_v[g]  = fec;
    assign st_v[g]   = st;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int sel);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Present a beat from a negedge; returns at the negedge after it was accepted.
  task automatic send(input int sel, input beat_t bt);
    int guard;
    guard = 0;
    va = bt.a; vb = bt.b; vci = bt.ci; vs = bt.s; vco = bt.co;
    vld = 1'b1;
    while (!rdy_v[sel] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_v[sel]) begin
      chk("send_ready_timeout", 0, 1);
      vld = 1'b0;
      return;
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int guard;
    guard = 0;
    while (!done_v[sel] && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("done_reached", done_v[sel], 1);
  endtask

  function automatic beat_t mk(input logic [15:0] a, input logic [15:0] b, input logic ci,
                               input logic [15:0] s, input logic co, input int e);
    beat_t r;
    r.a = a; r.b = b; r.ci = ci; r.s = s; r.co = co; r.exp_err_after = e;
    return r;
  endfunction

  function automatic beat_t good_beat(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    t = 17'(a) + 17'(b) + 17'(ci);
    return mk(a, b, ci, t[15:0], t[16], 0);
  endfunction

  beat_t tbl1 [4];
  beat_t tbl2 [3];
  bit    pat  [4];

  initial begin
    tbl1[0] = mk(16'd1,     16'd2,     1'b0, 16'd3,     1'b0, 0);
    tbl1[1] = mk(16'd65535, 16'd1,     1'b0, 16'd0,     1'b1, 0);
    tbl1[2] = mk(16'd65535, 16'd65535, 1'b1, 16'd65535, 1'b1, 0);
    tbl1[3] = mk(16'd0,     16'd0,     1'b1, 16'd1,     1'b0, 0);
    tbl2[0] = mk(16'd5, 16'd5, 1'b0, 16'd10, 1'b0, 0);
    tbl2[1] = mk(16'd7, 16'd1, 1'b0, 16'd9,  1'b0, 1);
    tbl2[2] = mk(16'd2, 16'd2, 1'b1, 16'd4,  1'b0, 2);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; vld = 1'b0;
    va = '0; vb = '0; vci = 1'b0; vs = '0; vco = 1'b0;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_state", st_v[i], 0);
      chk("reset_ready", rdy_v[i], 0);
      chk("reset_busy",  busy_v[i], 0);
      chk("reset_done",  done_v[i], 0);
      chk("reset_vec",   vec_v[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Clean back-to-back run of four beats
    pulse_start(0);
    chk("t1_ready_after_start", rdy_v[0], 1);
    for (int i = 0; i < 4; i++) send(0, tbl1[i]);
    chk("t1_ready_low_after_last", rdy_v[0], 0);
    chk("t1_state_drain", st_v[0], 2);
    chk("t1_done_k0", done_v[0], 0);
    @(negedge clk);
    chk("t1_vec_k1", vec_v[0], 4);
    chk("t1_done_k1", done_v[0], 0);
    @(negedge clk);
    chk("t1_done_k2", done_v[0], 1);
    chk("t1_pass", pass_v[0], 1);
    chk("t1_err", err_v[0], 0);
    chk("t1_fev", fev_v[0], 0);
    chk("t1_busy", busy_v[0], 0);

    // Two mismatches; first one captured; counters one edge after accept
    pulse_start(1);
    for (int i = 0; i < 3; i++) begin
      send(1, tbl2[i]);
      @(negedge clk);
      chk("t2_vec_step", vec_v[1], i + 1);
      chk("t2_err_step", err_v[1], tbl2[i].exp_err_after);
    end
    wait_done(1);
    chk("t2_err", err_v[1], 2);
    chk("t2_fea", fea_v[1], 7);
    chk("t2_feb", feb_v[1], 1);
    chk("t2_fec", fec_v[1], 0);
    chk("t2_pass", pass_v[1], 0);

    // Restart from DONE with errors, and a start during RUN is ignored
    pulse_start(1);
    chk("t6_vec_cleared", vec_v[1], 0);
    chk("t6_err_cleared", err_v[1], 0);
    chk("t6_fev_cleared", fev_v[1], 0);
    chk("t6_fea_cleared", fea_v[1], 0);
    chk("t6_ready", rdy_v[1], 1);
    chk("t6_done_low", done_v[1], 0);
    send(1, tbl1[0]);
    pulse_start(1);
    chk("t6_state_run", st_v[1], 1);
    chk("t6_vec_kept", vec_v[1], 1);
    send(1, tbl1[1]);
    send(1, tbl1[3]);
    wait_done(1);
    chk("t6_vec", vec_v[1], 3);
    chk("t6_pass", pass_v[1], 1);

    // Saturating 2-bit error counter
    pulse_start(3);
    for (int i = 0; i < 6; i++) begin
      send(3, mk(16'(i + 10), 16'(i + 3), 1'b0, 16'(2 * i + 14), 1'b0, 0));
    end
    wait_done(3);
    chk("t4_err_sat", err_v[3], 3);
    chk("t4_vec", vec_v[3], 6);
    chk("t4_pass", pass_v[3], 0);
    chk("t4_fea", fea_v[3], 10);
    chk("t4_feb", feb_v[3], 3);

    // in_valid toggling 1,0,0,1; junk payload whenever no transfer is meant
    begin
      int acc, cyc;
      logic was;
      acc = 0; cyc = 0;
      pulse_start(2);
      while (acc < 8 && cyc < 100) begin
        beat_t bt;
        bt = good_beat(16'($urandom), 16'($urandom), 1'($urandom));
        va = bt.a; vb = bt.b; vci = bt.ci; vco = bt.co;
        vld = pat[cyc % 4];
        vs = vld ? bt.s : bt.s + 16'd1;
        was = vld && rdy_v[2];
        @(negedge clk);
        if (was) acc++;
        cyc++;
      end
      chk("t3_accepts", acc, 8);
      vld = 1'b1; vs = vs + 16'd1;
      chk("t3_ready_low", rdy_v[2], 0);
      @(negedge clk);
      chk("t3_ready_low2", rdy_v[2], 0);
      vld = 1'b0;
      wait_done(2);
      chk("t3_vec", vec_v[2], 8);
      chk("t3_err", err_v[2], 0);
      chk("t3_pass", pass_v[2], 1);
    end

    // Randomized runs against a scoreboard of expected mismatching vectors
    for (int r = 0; r < 6; r++) begin
      exp_q.delete();
      pulse_start(2);
      for (int i = 0; i < 8; i++) begin
        beat_t bt;
        logic [16:0] res, truth;
        bt = good_beat(16'($urandom), 16'($urandom), 1'($urandom));
        truth = 17'(bt.a) + 17'(bt.b) + 17'(bt.ci);
        res = truth;
        if ($urandom_range(0, 2) == 0) res = res ^ (17'd1 << $urandom_range(0, 16));
        bt.s = res[15:0]; bt.co = res[16];
        if (res != truth) exp_q.push_back({bt.a, bt.b, bt.ci});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(2, bt);
      end
      wait_done(2);
      chk("rnd_vec", vec_v[2], 8);
      chk("rnd_err", err_v[2], exp_q.size());
      chk("rnd_pass", pass_v[2], exp_q.size() == 0);
      chk("rnd_fev", fev_v[2], exp_q.size() != 0);
      chk("rnd_fea", fea_v[2], (exp_q.size() != 0) ? exp_q[0][32:17] : 0);
      chk("rnd_feb", feb_v[2], (exp_q.size() != 0) ? exp_q[0][16:1] : 0);
      chk("rnd_fec", fec_v[2], (exp_q.size() != 0) ? exp_q[0][0] : 0);
    end

    // Asynchronous reset in the middle of a run, then a clean rerun
    pulse_start(0);
    send(0, tbl1[0]);
    send(0, tbl1[1]);
    chk("t5_busy_before", busy_v[0], 1);
    chk("t5_vec_before", vec_v[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t5_state", st_v[0], 0);
    chk("t5_busy", busy_v[0], 0);
    chk("t5_ready", rdy_v[0], 0);
    chk("t5_vec", vec_v[0], 0);
    chk("t5_err", err_v[0], 0);
    chk("t5_done", done_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_no_start", rdy_v[0], 0);
    pulse_start(0);
    for (int i = 0; i < 4; i++) send(0, tbl1[i]);
    wait_done(0);
    chk("t5_vec_rerun", vec_v[0], 4);
    chk("t5_pass_rerun", pass_v[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_response_checker.md
# adder_response_checker

Synthesizable response checker for the WIDTH-bit adder datapath. It receives a stream of applied vectors {a, b, c_in} together with the DUT's {sum, c_out} over a valid/ready handshake. For each vector it recomputes the expected result, compares it against the DUT result, and counts vectors and mismatches. It also latches the first failing vector. It is the receiving end for the exhaustive stimulus sweep and replaces display-based checking when the sweep runs on hardware.

## Interface
- WIDTH, 16, operand width of a, b, sum
- NUM_VECTORS, 2**(2*WIDTH+1), number of beats accepted per run; allowed range 1 to 2**CNT_W-1
- CNT_W, 34, width of vec_count
- ERR_W, 16, width of err_count; saturates at all-ones
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  input  1  beat present on a, b, c_in, sum, c_out
- in_ready  output  1  checker accepts beat this cycle
- a, b  input  WIDTH  applied operands
- c_in  input  1  applied carry-in
- sum  input  WIDTH  DUT sum
- c_out  input  1  DUT carry-out
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE
- pass  output  1  high in DONE when err_count == 0
- vec_count  output  CNT_W  beats compared this run
- err_count  output  ERR_W  mismatching beats this run
- first_err_valid  output  1  first-error capture holds data
- first_err_a, first_err_b  output  WIDTH  operands of the first mismatch
- first_err_c_in  output  1  carry-in of the first mismatch

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the edge that accepts beat number NUM_VECTORS.
  - DRAIN -> DONE when the compare pipeline is empty.
  - DONE -> RUN on start.
- start in RUN or DRAIN is ignored.
- Entering RUN clears vec_count, err_count, first_err_valid and all first_err_* fields in the same edge.
- in_ready = (state == RUN). Registered accept counter acc_cnt counts handshakes.
- A beat transfers only when in_valid && in_ready at a rising edge. No other input is sampled.
- Stage 1, on the accept edge: register a, b, c_in, sum, c_out and set s1_valid.
- Stage 2, next edge, if s1_valid:
  - expected = a + b + c_in, computed at WIDTH+1 bits; MSB is the expected c_out.
  - mismatch = ({c_out, sum} != expected).
  - vec_count increments by 1.
  - err_count increments by 1 on mismatch, saturating at 2**ERR_W-1.
- First mismatch of a run: if first_err_valid == 0, latch the stage-1 a, b, c_in and set first_err_valid. Later mismatches do not overwrite it.
- pass = done && (err_count == 0); 0 outside DONE.
- vec_count has no wrap in a legal run because NUM_VECTORS < 2**CNT_W.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready, busy, done, pass, first_err_valid, s1_valid = 0.
  - All counters and first_err_* = 0.
- Reset may assert mid-run. The run is abandoned with no partial completion, and a new start is required.
- Latency: a beat accepted at edge k is reflected in vec_count and err_count after edge k+1.
- Back-to-back beats are supported at 1 per cycle. in_valid gaps simply stall; there is no timeout.
- The last beat is accepted at edge k. in_ready drops after edge k, counters update at k+1, and done rises after edge k+2.
- A start pulse coinciding with an accept in DONE is impossible because in_ready = 0 in DONE.
- A start edge from DONE clears counters and enters RUN. in_ready is high the following cycle.

## Test plan
- NUM_VECTORS=4, beats (1,2,0,sum=3,c_out=0), (65535,1,0,0,1), (65535,65535,1,65535,1), (0,0,1,1,0), back-to-back. Required: vec_count=4, err_count=0, pass=1, done two cycles after the last accept.
- NUM_VECTORS=3, beats (5,5,0,10,0), (7,1,0,9,0), (2,2,1,4,0). Required: err_count=2, first_err_a=7, first_err_b=1, first_err_c_in=0, pass=0.
- NUM_VECTORS=8, in_valid toggling 1,0,0,1. Required: only handshaked beats counted, vec_count=8 at done, in_ready low after the 8th accept.
- ERR_W=2, NUM_VECTORS=6, all beats wrong. Required: err_count saturates at 3, vec_count=6.
- Assert rst_n low after 2 of 4 beats. Required: all outputs zero and state IDLE immediately. Then start plus 4 clean beats gives vec_count=4, pass=1.
- From DONE with errors, pulse start. Required: counters and first_err_valid cleared on that edge, in_ready=1 next cycle. A second start in RUN has no effect.
